dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the RISC-V pipeline's memory stage. It accepts load/store requests issued in M, applies a fixed number of wait states, and returns sign- or zero-extended load data on `read_data_m`. That data is then captured into the M/W pipeline register. While an access is in flight it holds the front of the pipeline with `stall_m`, so the M/W register only advances on the response cycle.

## Interface
- `DEPTH_WORDS`, 256 — number of 32-bit words in the array; word index = `req_addr_m[31:2]` mod `DEPTH_WORDS`.
- `WAIT_STATES`, 2 — extra cycles between acceptance and response; legal range 0..15.
- `clk` in 1 — single clock; all state updates on its rising edge.
- `reset` in 1 — synchronous, active-low; `reset==0` at a rising edge resets.
- `req_valid_m` in 1 — memory-stage request present; held until the response cycle.
- `req_we_m` in 1 — 1 = store, 0 = load.
- `req_addr_m` in 32 — byte address, little-endian.
- `req_funct3_m` in 3 — access size: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- `req_wdata_m` in 32 — store data, right-justified.
- `stall_m` out 1 — hold F/D/E/M and the M/W register.
- `resp_valid` out 1 — one-cycle response strobe.
- `read_data_m` out 32 — registered load result.
- `access_err` out 1 — registered; valid with `resp_valid`.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If `req_valid_m==1`, capture `req_we_m`, `req_addr_m`, `req_funct3_m` and `req_wdata_m` into internal registers.
  - If the request is erroneous, go to RESP.
  - Else if `WAIT_STATES==0`, go to RESP.
  - Else load the wait counter with `WAIT_STATES-1` and go to WAIT.
- WAIT: when the counter is 0, go to RESP; otherwise decrement it.
- RESP: always returns to IDLE. A request visible during RESP belongs to the completing instruction and is never re-accepted.
- An access is erroneous when any of the following holds. Erroneous accesses touch no memory.
  - Halfword with `addr[0]==1`.
  - Word with `addr[1:0]!=0`.
  - Store with funct3 other than 000, 001 or 010.
  - funct3 of 011, 110 or 111.
- Memory update and `read_data_m`/`access_err` loading both occur on the edge that enters RESP, using captured values only.
  - Store: write only the addressed bytes. sb writes byte `addr[1:0]` from `wdata[7:0]`; sh writes bytes `{addr[1],0}` and `{addr[1],1}` from `wdata[15:0]`; sw writes all four bytes. `read_data_m` becomes 0.
  - Load: `read_data_m` takes the selected byte or halfword, sign-extended (lb, lh) or zero-extended (lbu, lhu), or the full word for lw.
  - Error: `read_data_m` becomes 0 and `access_err` becomes 1; otherwise `access_err` becomes 0.
- `read_data_m` and `access_err` hold their values until the next RESP entry.
- Array contents are not initialised and are not cleared by reset.

## Timing
- Reset values: FSM in IDLE, wait counter 0, `resp_valid=0`, `stall_m=0`, `read_data_m=0`, `access_err=0`.
- `stall_m` is combinational: `(state==IDLE && req_valid_m) || state==WAIT`. It is 0 in RESP, so the M/W register captures `read_data_m` at the end of the RESP cycle.
- `resp_valid` is high exactly while the state is RESP.
- Legal request: the request is held for `WAIT_STATES+2` cycles and `stall_m` is high for `WAIT_STATES+1` of them. With `WAIT_STATES=2` this is 4 cycles, 3 stalled.
- Erroneous request: 2 cycles, 1 stalled, regardless of `WAIT_STATES`.
- Back-to-back requests: the earliest next acceptance is the cycle after RESP. There are no bubbles beyond the IDLE accept cycle.
- Request inputs may change during WAIT without effect, because captured values are used.
- Reset mid-access, in WAIT or at the RESP entry edge: return to IDLE with outputs at reset values. A pending store is dropped and its memory bytes are unchanged. Reset takes priority over every transition, including the store write.
- `req_valid_m==0` in IDLE: no state change and `stall_m=0`.

## Test plan
- Reset with `reset=0` for 2 cycles, then release: `stall_m=0`, `resp_valid=0`, `read_data_m=0`, `access_err=0`.
- sw `0xDEADBEEF` to `0x10`, then lw `0x10` with `WAIT_STATES=2`:
  - Each access has 3 stall cycles, then `resp_valid` on the 4th cycle.
  - The load returns `0xDEADBEEF`.
- After the word above:
  - lb `0x13` gives `0xFFFFFFDE`.
  - lbu `0x13` gives `0x000000DE`.
  - lh `0x12` gives `0xFFFFDEAD`.
  - lhu `0x10` gives `0x0000BEEF`.
  - Then sb `0x55` to `0x11` and lw `0x10`: returns `0xDEAD55EF`.
- lw at `0x12`, sh at `0x13`, and funct3=011:
  - `stall_m` high for exactly 1 cycle, then `resp_valid=1`, `access_err=1`, `read_data_m=0`.
  - A following lw `0x10` shows memory unchanged.
- sw `0x12345678` to `0x20`, asserting `reset=0` in the second WAIT cycle:
  - Next cycle is IDLE with `stall_m=0`.
  - After release, lw `0x20` returns its pre-store value.
- `WAIT_STATES=0` with lw then sw issued back-to-back: each has 1 stall cycle, `resp_valid` on the 2nd cycle, and the lw is not re-accepted during RESP.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline and dmem_responder.
// The pipeline drives requests as master; the responder answers as slave.
interface dmem_responder_if;
  logic        req_valid_m;
  logic        req_we_m;
  logic [31:0] req_addr_m;
  logic [2:0]  req_funct3_m;
  logic [31:0] req_wdata_m;
  logic        stall_m;
  logic        resp_valid;
  logic [31:0] read_data_m;
  logic        access_err;

  modport master (
    output req_valid_m, req_we_m, req_addr_m, req_funct3_m, req_wdata_m,
    input  stall_m, resp_valid, read_data_m, access_err
  );

  modport slave (
    input  req_valid_m, req_we_m, req_addr_m, req_funct3_m, req_wdata_m,
    output stall_m, resp_valid, read_data_m, access_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: fixed wait states, byte-lane stores,
// sign/zero-extended loads, misalignment/illegal-size error reporting.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic       ZERO_WAIT = (WAIT_STATES == 32'sd0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 32'sd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic access_error(input logic we, input logic [1:0] lo,
                                        input logic [2:0] f3);
    logic err;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = lo[0];
      3'b010:  err = (lo != 2'b00);
      3'b100:  err = we;
      3'b101:  err = we | lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] lo, input logic [2:0] f3);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << lo;
      3'b001:  be = lo[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [2:0] f3);
    logic [31:0] lanes;
    case (f3)
      3'b000:  lanes = {4{wdata[7:0]}};
      3'b001:  lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  state_t      state_r, next_state_s;
  logic [3:0]  cnt_r, cnt_next_s;
  logic        capture_s, enter_resp_s;
  logic        we_r;
  logic [31:0] addr_r, wdata_r;
  logic [2:0]  funct3_r;
  logic [31:0] read_data_r;
  logic        access_err_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  logic        op_we_s, op_err_s;
  logic [31:0] op_addr_s, op_wdata_s, op_word_s;
  logic [2:0]  op_funct3_s;
  logic [IDX_W-1:0] word_idx_s;
  logic [3:0]  op_be_s;
  logic [31:0] op_lanes_s;

  // In IDLE the request is resolved on the same edge it is captured, so the live inputs stand in for the registers.
  always_comb begin
    if (state_r == ST_IDLE) begin
      op_we_s     = bus.req_we_m;
      op_addr_s   = bus.req_addr_m;
      op_funct3_s = bus.req_funct3_m;
      op_wdata_s  = bus.req_wdata_m;
    end else begin
      op_we_s     = we_r;
      op_addr_s   = addr_r;
      op_funct3_s = funct3_r;
      op_wdata_s  = wdata_r;
    end
    op_err_s   = access_error(op_we_s, op_addr_s[1:0], op_funct3_s);
    word_idx_s = IDX_W'(op_addr_s[31:2] % 30'(DEPTH_WORDS));
    op_word_s  = mem_r[word_idx_s];
    op_be_s    = byte_enable(op_addr_s[1:0], op_funct3_s);
    op_lanes_s = store_lanes(op_wdata_s, op_funct3_s);
  end

  // Next-state and wait-counter logic.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid_m) begin
          capture_s = 1'b1;
          if (op_err_s || ZERO_WAIT) begin
            next_state_s = ST_RESP;
          end else begin
            cnt_next_s   = WAIT_LOAD;
            next_state_s = ST_WAIT;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          next_state_s = ST_RESP;
        end else begin
          cnt_next_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
    enter_resp_s = (next_state_s == ST_RESP) && (state_r != ST_RESP);
  end

  // State, counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      read_data_r  <= 32'd0;
      access_err_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      if (enter_resp_s) begin
        access_err_r <= op_err_s;
        read_data_r  <= (op_err_s || op_we_s) ? 32'd0
                                              : load_extend(op_word_s, op_addr_s[1:0], op_funct3_s);
      end
    end
  end

  // Request capture registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_r     <= 1'b0;
      addr_r   <= 32'd0;
      funct3_r <= 3'd0;
      wdata_r  <= 32'd0;
    end else if (capture_s) begin
      we_r     <= bus.req_we_m;
      addr_r   <= bus.req_addr_m;
      funct3_r <= bus.req_funct3_m;
      wdata_r  <= bus.req_wdata_m;
    end
  end

  // Byte-lane store into the array; a reset on the same edge drops the store.
  always_ff @(posedge clk) begin
    if (reset && enter_resp_s && op_we_s && !op_err_s) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be_s[b]) begin
          mem_r[word_idx_s][8*b +: 8] <= op_lanes_s[8*b +: 8];
        end
      end
    end
  end

  assign bus.stall_m     = ((state_r == ST_IDLE) && bus.req_valid_m) || (state_r == ST_WAIT);
  assign bus.resp_valid  = (state_r == ST_RESP);
  assign bus.read_data_m = read_data_r;
  assign bus.access_err  = access_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// accesses against a byte-addressed reference memory, on WAIT_STATES=2 and 0.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sel0;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_f3;
  logic        o_stall, o_resp, o_err;
  logic [31:0] o_rd;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mem_m [int];

  dmem_responder_if bus2();
  dmem_responder_if bus0();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  assign bus2.req_valid_m  = req_valid & ~sel0;
  assign bus2.req_we_m     = req_we;
  assign bus2.req_addr_m   = req_addr;
  assign bus2.req_funct3_m = req_f3;
  assign bus2.req_wdata_m  = req_wdata;
  assign bus0.req_valid_m  = req_valid & sel0;
  assign bus0.req_we_m     = req_we;
  assign bus0.req_addr_m   = req_addr;
  assign bus0.req_funct3_m = req_f3;
  assign bus0.req_wdata_m  = req_wdata;

  assign o_stall = sel0 ? bus0.stall_m     : bus2.stall_m;
  assign o_resp  = sel0 ? bus0.resp_valid  : bus2.resp_valid;
  assign o_rd    = sel0 ? bus0.read_data_m : bus2.read_data_m;
  assign o_err   = sel0 ? bus0.access_err  : bus2.access_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic int key(input logic s, input logic [31:0] a);
    return (s ? 32'h10000 : 0) + int'(a);
  endfunction

  // Drive one request from a negedge until its response; returns at the following negedge with valid dropped.
  task automatic run_acc(input logic s, input logic we, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_st);
    int n, st;
    logic got, er;
    logic [31:0] rd;
    sel0 = s; req_valid = 1'b1; req_we = we; req_addr = a; req_f3 = f3; req_wdata = wd;
    n = 0; st = 0; got = 1'b0; er = 1'b0; rd = 32'd0;
    while (!got && n < 40) begin
      #1;
      n++;
      if (o_stall === 1'b1) st++;
      if (o_resp === 1'b1) begin
        got = 1'b1; rd = o_rd; er = o_err;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("resp_seen", 32'(got), 32'd1);
    chk("stall_cycles", 32'(st), 32'(exp_st));
    chk("resp_cycle", 32'(n), 32'(exp_st + 1));
    chk("access_err", 32'(er), 32'(exp_err));
    chk("read_data", rd, exp_rd);
  endtask

  // Reference: errors, latency and data derived from the access rules on a byte-addressed memory.
  task automatic model_acc(input logic s, input logic we, input logic [31:0] a, input logic [2:0] f3,
                           input logic [31:0] wd);
    int n;
    logic err;
    longint v;
    logic [31:0] tmp, expv;
    n = 1 << f3[1:0];
    err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) || ((a % n) != 0);
    expv = 32'd0;
    if (!err && we) begin
      for (int i = 0; i < n; i++) begin
        tmp = wd >> (8 * i);
        mem_m[key(s, a + i)] = tmp[7:0];
      end
    end else if (!err) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(mem_m[key(s, a + i)]) << (8 * i));
      if (f3 < 3'd4 && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      expv = v[31:0];
    end
    run_acc(s, we, a, f3, wd, expv, err, err ? 1 : (s ? 1 : 3));
  endtask

  initial begin
    reset = 1'b0; sel0 = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'd0; req_f3 = 3'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_stall", 32'(bus2.stall_m), 32'd0);
    chk("rst_resp", 32'(bus2.resp_valid), 32'd0);
    chk("rst_rd", bus2.read_data_m, 32'd0);
    chk("rst_err", 32'(bus2.access_err), 32'd0);
    chk("rst_resp0", 32'(bus0.resp_valid), 32'd0);
    @(negedge clk);

    for (int w = 0; w < 16; w++) begin
      model_acc(1'b0, 1'b1, 32'h100 + 32'(4 * w), 3'b010, $urandom);
      model_acc(1'b1, 1'b1, 32'h100 + 32'(4 * w), 3'b010, $urandom);
    end

    model_acc(1'b0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
    run_acc(1'b0, 1'b0, 32'h10, 3'b010, 32'd0, 32'hDEADBEEF, 1'b0, 3);
    run_acc(1'b0, 1'b0, 32'h13, 3'b000, 32'd0, 32'hFFFFFFDE, 1'b0, 3);
    run_acc(1'b0, 1'b0, 32'h13, 3'b100, 32'd0, 32'h000000DE, 1'b0, 3);
    run_acc(1'b0, 1'b0, 32'h12, 3'b001, 32'd0, 32'hFFFFDEAD, 1'b0, 3);
    run_acc(1'b0, 1'b0, 32'h10, 3'b101, 32'd0, 32'h0000BEEF, 1'b0, 3);
    model_acc(1'b0, 1'b1, 32'h11, 3'b000, 32'h00000055);
    run_acc(1'b0, 1'b0, 32'h10, 3'b010, 32'd0, 32'hDEAD55EF, 1'b0, 3);

    run_acc(1'b0, 1'b0, 32'h12, 3'b010, 32'd0, 32'd0, 1'b1, 1);
    run_acc(1'b0, 1'b1, 32'h13, 3'b001, 32'hA5A5A5A5, 32'd0, 1'b1, 1);
    run_acc(1'b0, 1'b1, 32'h10, 3'b011, 32'h11111111, 32'd0, 1'b1, 1);
    run_acc(1'b0, 1'b0, 32'h10, 3'b010, 32'd0, 32'hDEAD55EF, 1'b0, 3);

    // Store to 0x20 interrupted by reset in its second WAIT cycle.
    model_acc(1'b0, 1'b1, 32'h20, 3'b010, 32'hCAFEF00D);
    sel0 = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_f3 = 3'b010; req_wdata = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_stall", 32'(o_stall), 32'd0);
    chk("midrst_resp", 32'(o_resp), 32'd0);
    chk("midrst_rd", o_rd, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    run_acc(1'b0, 1'b0, 32'h20, 3'b010, 32'd0, 32'hCAFEF00D, 1'b0, 3);

    // Zero wait states, back-to-back lw then sw.
    model_acc(1'b1, 1'b1, 32'h40, 3'b010, 32'h0BADCAFE);
    @(negedge clk);
    run_acc(1'b1, 1'b0, 32'h40, 3'b010, 32'd0, 32'h0BADCAFE, 1'b0, 1);
    model_acc(1'b1, 1'b1, 32'h44, 3'b010, 32'h76543210);
    #1;
    chk("ws0_idle_resp", 32'(o_resp), 32'd0);
    chk("ws0_idle_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    run_acc(1'b1, 1'b0, 32'h44, 3'b010, 32'd0, 32'h76543210, 1'b0, 1);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      model_acc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'h100 + 32'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
